// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_e : fetch FSM states
//   pc_sel_e      : next-PC source after priority resolution
//   redir_sel()   : priority encoder, trap > branch/jump > sequential
package pc_fetch_ctrl_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

  typedef enum logic [1:0] {SEL_SEQ, SEL_REDIR, SEL_TRAP} pc_sel_e;

  function automatic pc_sel_e redir_sel(input logic trap_valid, input logic redir_valid);
    if (trap_valid)       return SEL_TRAP;
    else if (redir_valid) return SEL_REDIR;
    else                  return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_add_4.sv
// Constant +4 incrementer for the program counter, wraps modulo 2^XLEN.
//   a : input address
//   y : a + 4
module add_4 #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  output logic [XLEN-1:0] y
);

  assign y = a + XLEN'(4);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, picks the next PC (trap > redirect > pc+4),
// runs a one-outstanding req/gnt/rvalid handshake to instruction memory and
// holds a {pc, instr, pc+4} bundle for decode until it is consumed.
//   clk, rst                 : clock, async active-high reset
//   stall_i                  : decode cannot accept, hold if_* bundle
//   trap_valid_i/trap_vec_i  : trap request and target
//   redir_valid_i/redir_pc_i : taken branch/jump and target
//   imem_*                   : instruction memory request/grant/response
//   if_valid_o, if_pc_o, if_instr_o, if_pc4_o : bundle to decode
//   misalign_o               : one-cycle pulse, accepted target had [1:0] != 0
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            redir_valid_i,
  input  logic [XLEN-1:0] redir_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc4_o,
  output logic            misalign_o
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n, pc4;
  logic            kill, kill_n;
  logic            if_valid, if_valid_n;
  logic [XLEN-1:0] if_pc, if_pc_n, if_pc4, if_pc4_n;
  logic [31:0]     if_instr, if_instr_n;
  logic            misalign, misalign_n;

  pc_sel_e         sel;
  logic [XLEN-1:0] target;
  logic            take;

  // One incrementer serves both the sequential next pc and the link address.
  add_4 #(.XLEN(XLEN)) u_add_4 (.a(pc), .y(pc4));

  assign sel    = redir_sel(trap_valid_i, redir_valid_i);
  assign target = (sel == SEL_TRAP) ? trap_vec_i : redir_pc_i;
  // Redirects are ignored in IDLE; the first fetch after reset is always RESET_VEC.
  assign take   = (sel != SEL_SEQ) && (state != IDLE);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    if_valid_n = if_valid;
    if_pc_n    = if_pc;
    if_instr_n = if_instr;
    if_pc4_n   = if_pc4;
    misalign_n = 1'b0;

    if (take) begin
      pc_n       = {target[XLEN-1:2], 2'b00};
      misalign_n = |target[1:0];
      if_valid_n = 1'b0;
    end

    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // A redirect coinciding with the grant leaves a stale response in flight.
        if (imem_gnt_i) begin
          state_n = WAIT;
          kill_n  = take;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_n = REQ;
          kill_n  = 1'b0;
          if (!kill && !take) begin
            if_valid_n = 1'b1;
            if_pc_n    = pc;
            if_instr_n = imem_rdata_i;
            if_pc4_n   = pc4;
            pc_n       = pc4;
            state_n    = HOLD;
          end
        end else if (take) begin
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (take || !stall_i) begin
          if_valid_n = 1'b0;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NOP_INSTR;
      if_pc4   <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      if_valid <= if_valid_n;
      if_pc    <= if_pc_n;
      if_instr <= if_instr_n;
      if_pc4   <= if_pc4_n;
      misalign <= misalign_n;
    end
  end

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;
  assign if_valid_o  = if_valid;
  assign if_pc_o     = if_pc;
  assign if_instr_o  = if_instr;
  assign if_pc4_o    = if_pc4;
  assign misalign_o  = misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_vec_i = '0;
  logic        redir_valid_i = 1'b0;
  logic [31:0] redir_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc4_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .trap_valid_i(trap_valid_i), .trap_vec_i(trap_vec_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .if_pc4_o(if_pc4_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", if_pc_o); end
    checks++; if (if_pc4_o !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 00000000", if_pc4_o); end
    checks++; if (if_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h want 00000013", if_instr_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
    rst = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_req_o); end
  endtask

  task automatic test_basic();
    tick();
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL b_req0: got %b want 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL b_addr0: got %h want 00000000", imem_addr_o); end
    imem_gnt_i = 1'b1;
    tick();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL b_wait_req: got %b want 0", imem_req_o); end
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA000_0000;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL b_valid: got %b want 1", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL b_pc: got %h want 00000000", if_pc_o); end
    checks++; if (if_pc4_o !== 32'h4) begin errors++; $display("FAIL b_pc4: got %h want 00000004", if_pc4_o); end
    checks++; if (if_instr_o !== 32'hA000_0000) begin errors++; $display("FAIL b_instr: got %h want a0000000", if_instr_o); end
    tick();
    checks++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b1) begin errors++; $display("FAIL b_addr4: got %h req %b want 00000004 req 1", imem_addr_o, imem_req_o); end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA000_0004;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_pc_o !== 32'h4) begin errors++; $display("FAIL b_pc_4: got %h want 00000004", if_pc_o); end
    tick();
    checks++; if (imem_addr_o !== 32'h8 || imem_req_o !== 1'b1) begin errors++; $display("FAIL b_addr8: got %h req %b want 00000008 req 1", imem_addr_o, imem_req_o); end
  endtask

  task automatic test_stall();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA000_0008;
    tick();
    imem_rvalid_i = 1'b0;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_instr_o !== 32'hA000_0008 || imem_req_o !== 1'b0)
        begin errors++; $display("FAIL s_hold%0d: got v=%b pc=%h instr=%h req=%b want v=1 pc=00000008 instr=a0000008 req=0", i, if_valid_o, if_pc_o, if_instr_o, imem_req_o); end
    end
    stall_i = 1'b0;
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC || if_valid_o !== 1'b0)
      begin errors++; $display("FAIL s_release: got req=%b addr=%h v=%b want req=1 addr=0000000c v=0", imem_req_o, imem_addr_o, if_valid_o); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; redir_valid_i = 1'b1; redir_pc_i = 32'h100;
    tick();
    redir_valid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL rw_wait: got req=%b v=%b want req=0 v=0", imem_req_o, if_valid_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL rw_stale: got v=%b want 0", if_valid_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL rw_addr: got req=%b addr=%h want req=1 addr=00000100", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_trap_priority();
    trap_valid_i = 1'b1; trap_vec_i = 32'h80; redir_valid_i = 1'b1; redir_pc_i = 32'h200;
    tick();
    trap_valid_i = 1'b0; redir_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h80 || imem_req_o !== 1'b1) begin errors++; $display("FAIL tp_addr: got %h req %b want 00000080 req 1", imem_addr_o, imem_req_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL tp_misalign: got %b want 0", misalign_o); end
    redir_valid_i = 1'b1; redir_pc_i = 32'h103;
    tick();
    redir_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL ma_addr: got %h want 00000100", imem_addr_o); end
    checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL ma_pulse: got %b want 1", misalign_o); end
    tick();
    checks++; if (misalign_o !== 1'b0 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL ma_end: got m=%b addr=%h want m=0 addr=00000100", misalign_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    redir_valid_i = 1'b1; redir_pc_i = 32'hFFFF_FFFC;
    tick();
    redir_valid_i = 1'b0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL w_addr: got %h want fffffffc", imem_addr_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC)
        begin errors++; $display("FAIL w_nognt%0d: got req=%b addr=%h want req=1 addr=fffffffc", i, imem_req_o, imem_addr_o); end
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_pc_o !== 32'hFFFF_FFFC || if_pc4_o !== 32'h0 || if_instr_o !== 32'h1234_5678)
      begin errors++; $display("FAIL w_bundle: got pc=%h pc4=%h instr=%h want fffffffc 00000000 12345678", if_pc_o, if_pc4_o, if_instr_o); end
    tick();
    checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL w_next: got %h req %b want 00000000 req 1", imem_addr_o, imem_req_o); end
  endtask

  task automatic test_redirect_hold();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0093;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_pc4_o !== 32'h4)
      begin errors++; $display("FAIL rh_bundle: got v=%b pc=%h pc4=%h want 1 00000000 00000004", if_valid_o, if_pc_o, if_pc4_o); end
    stall_i = 1'b1; redir_valid_i = 1'b1; redir_pc_i = 32'h40;
    tick();
    redir_valid_i = 1'b0; stall_i = 1'b0;
    checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40)
      begin errors++; $display("FAIL rh_discard: got v=%b req=%b addr=%h want v=0 req=1 addr=00000040", if_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0 || misalign_o !== 1'b0)
      begin errors++; $display("FAIL rm_ctrl: got req=%b addr=%h v=%b m=%b want 0 00000000 0 0", imem_req_o, imem_addr_o, if_valid_o, misalign_o); end
    checks++; if (if_instr_o !== 32'h0000_0013 || if_pc4_o !== 32'h0 || if_pc_o !== 32'h0)
      begin errors++; $display("FAIL rm_data: got instr=%h pc4=%h pc=%h want 00000013 00000000 00000000", if_instr_o, if_pc4_o, if_pc_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL rm_idle: got req=%b v=%b want 0 0", imem_req_o, if_valid_o); end
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0)
      begin errors++; $display("FAIL rm_req: got req=%b addr=%h v=%b want 1 00000000 0", imem_req_o, imem_addr_o, if_valid_o); end
    tick();
    checks++; if (imem_req_o !== 1'b1 || if_valid_o !== 1'b0) begin errors++; $display("FAIL rm_late: got req=%b v=%b want 1 0", imem_req_o, if_valid_o); end
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0040_0093;
    tick();
    imem_rvalid_i = 1'b0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0040_0093)
      begin errors++; $display("FAIL rm_refetch: got v=%b pc=%h instr=%h want 1 00000000 00400093", if_valid_o, if_pc_o, if_instr_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_trap_priority();
    test_wrap();
    test_redirect_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
